// File: rtl/cpu_pkg.sv
// Shared definitions for the 24-bit single-cycle CPU front end:
// opcode constants, instruction field positions and the fetch state encoding.
package cpu_pkg;

  // Opcode encodings (instr[23:20])
  localparam logic [3:0] OP_RTYPE = 4'b0110;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LS    = 4'b0010;
  localparam logic [3:0] OP_SS    = 4'b0011;
  localparam logic [3:0] OP_BR    = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // Instruction field bit positions
  localparam int OPCODE_MSB = 23;
  localparam int OPCODE_LSB = 20;
  localparam int RS_MSB     = 19;
  localparam int RS_LSB     = 16;
  localparam int RT_MSB     = 15;
  localparam int RT_LSB     = 12;
  localparam int IMM_MSB    = 11;
  localparam int IMM_LSB    = 0;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 8;
  localparam int FUNCT_MSB  = 7;
  localparam int FUNCT_LSB  = 0;

  localparam int IMM_W = IMM_MSB - IMM_LSB + 1;

  // Fetch unit control states
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    ISSUE = 2'b01,
    HALT  = 2'b10
  } fetch_state_e;

  // True for every opcode the decoder understands, HALT included.
  function automatic logic is_legal_opcode(input logic [3:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_ADDI, OP_LS, OP_SS, OP_BR, OP_HALT: legal = 1'b1;
      default:                                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the instruction-memory request/ack port and the issue
// valid/ready port of the fetch unit. The fetch unit is the master;
// instruction memory plus decoder/datapath form the slave side.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 24
);

  // Instruction memory side
  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_rdata;

  // Issue side toward decoder and datapath
  logic                issue_valid;
  logic                issue_ready;
  logic [INSTR_W-1:0]  instr;
  logic [3:0]          OPCODE;
  logic [ADDR_W-1:0]   pc;
  logic                Branch;
  logic                BranchCond;

  // Status
  logic                halted;
  logic                illegal_op;

  modport master (
    output imem_req, imem_addr, issue_valid, instr, OPCODE, pc, halted, illegal_op,
    input  imem_ack, imem_rdata, issue_ready, Branch, BranchCond
  );

  modport slave (
    input  imem_req, imem_addr, issue_valid, instr, OPCODE, pc, halted, illegal_op,
    output imem_ack, imem_rdata, issue_ready, Branch, BranchCond
  );

endinterface

// File: rtl/instruction_fetch_unit_next_pc.sv
// next_pc_calc: sequential successor of pc, optionally displaced by the
// sign-extended 12-bit immediate. Everything wraps modulo 2^ADDR_W.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm12,
  input  logic              take_branch,
  output logic [ADDR_W-1:0] next_pc
);

  // Wide enough to hold both the sign-extended immediate and the pc.
  localparam int EXT_W = (ADDR_W > IMM_W) ? ADDR_W : IMM_W;

  logic [EXT_W-1:0]  imm_ext;
  logic [ADDR_W-1:0] offset;
  logic              unused_imm_bits;

  // Sign-extend, truncate to the pc width and add pc + 1.
  always_comb begin
    imm_ext         = EXT_W'($signed(imm12));
    // Bits above ADDR_W vanish in the modulo sum.
    unused_imm_bits = ^imm_ext;
    offset          = take_branch ? imm_ext[ADDR_W-1:0] : '0;
    next_pc         = pc + ADDR_W'(1) + offset;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches 24-bit words over a
// req/ack handshake, issues them under valid/ready, resolves branches
// on issue acceptance, drops illegal opcodes and stops on HALT.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter int                INSTR_W  = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  instruction_fetch_unit_if.master bus
);

  fetch_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 imem_req_q, imem_req_d;
  logic                 issue_valid_q, issue_valid_d;
  logic                 halted_q, halted_d;
  logic                 illegal_op_q, illegal_op_d;

  logic [3:0]           fetched_op;
  logic                 take_branch;
  logic [ADDR_W-1:0]    next_pc;

  // Branch inputs only matter on the cycle an issued instruction is accepted;
  // in every other state the calculator yields pc + 1.
  assign take_branch = (state_q == ISSUE) & bus.Branch & bus.BranchCond;

  next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc          (pc_q),
    .imm12       (instr_q[IMM_MSB:IMM_LSB]),
    .take_branch (take_branch),
    .next_pc     (next_pc)
  );

  assign fetched_op = bus.imem_rdata[OPCODE_MSB:OPCODE_LSB];

  // Next-state and next-output logic for the FETCH / ISSUE / HALT controller.
  always_comb begin
    // NOTE: every _d gets a default first so no path through the case can infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    imem_req_d    = 1'b0;
    issue_valid_d = 1'b0;
    halted_d      = halted_q;
    illegal_op_d  = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req_d = 1'b1;
        // An ack only counts while our request is actually on the bus.
        if (imem_req_q && bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          if (fetched_op == OP_HALT) begin
            state_d    = HALT;
            halted_d   = 1'b1;
            imem_req_d = 1'b0;
          end else if (!is_legal_opcode(fetched_op)) begin
            // Skip the word and immediately request the next one.
            illegal_op_d = 1'b1;
            pc_d         = next_pc;
          end else begin
            state_d       = ISSUE;
            issue_valid_d = 1'b1;
            imem_req_d    = 1'b0;
          end
        end
      end

      ISSUE: begin
        issue_valid_d = 1'b1;
        if (bus.issue_ready) begin
          pc_d          = next_pc;
          state_d       = FETCH;
          issue_valid_d = 1'b0;
          imem_req_d    = 1'b1;
        end
      end

      HALT: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      issue_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      illegal_op_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      issue_valid_q <= issue_valid_d;
      halted_q      <= halted_d;
      illegal_op_q  <= illegal_op_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.instr       = instr_q;
  assign bus.OPCODE      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.illegal_op  = illegal_op_q;

endmodule
